// File: rtl/alu_operand_stage.sv
// Operand-select pipeline register between decode and the ALU: picks the operand
// sources, optionally forwards from EX/MEM and MEM/WB, and registers them for
// one cycle. Build with ALU_OPERAND_FORWARDING_EN defined to enable forwarding.
module alu_operand_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic        src1_sel,
   input  logic        src2_sel,
   input  logic [3:0]  alu_op,
   input  logic [4:0]  rd_addr,
   input  logic        reg_write,
   input  logic        stall,
   input  logic        flush,
   input  logic [4:0]  exmem_rd,
   input  logic [4:0]  memwb_rd,
   input  logic        exmem_regwrite,
   input  logic        memwb_regwrite,
   input  logic [31:0] exmem_result,
   input  logic [31:0] memwb_result,
   output logic        out_valid,
   output logic [31:0] alu_input1,
   output logic [31:0] alu_input2,
   output logic [3:0]  alu_operation,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic [31:0] out_rs2_data
);

   typedef struct packed {
      logic [31:0] a1;
      logic [31:0] a2;
      logic [31:0] rs2;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        rw;
   } pkt_t;

   pkt_t        q, d;
   logic        vld_q;
   logic [31:0] fwd_rs1, fwd_rs2;

`ifdef ALU_OPERAND_FORWARDING_EN
   // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
   function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
      if (exmem_regwrite && exmem_rd == a && a != 5'd0)
         return exmem_result;
      else if (memwb_regwrite && memwb_rd == a && a != 5'd0)
         return memwb_result;
      else
         return rf;
   endfunction

   assign fwd_rs1 = fwd(rs1_addr, rs1_data);
   assign fwd_rs2 = fwd(rs2_addr, rs2_data);
`else
   logic unused_fwd;
   assign unused_fwd = ^{exmem_rd, memwb_rd, exmem_regwrite, memwb_regwrite,
                         exmem_result, memwb_result};
   assign fwd_rs1    = rs1_data;
   assign fwd_rs2    = rs2_data;
`endif

   always_comb begin
      d     = '0;
      d.a1  = src1_sel ? pc  : fwd_rs1;
      d.a2  = src2_sel ? imm : fwd_rs2;
      d.rs2 = fwd_rs2;
      d.op  = alu_op;
      d.rd  = rd_addr;
      d.rw  = reg_write;
   end

   // Write-enable is cleared with every invalidation so it can never outlive valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= '0;
         vld_q <= 1'b0;
      end else if (flush) begin
         vld_q <= 1'b0;
         q.rw  <= 1'b0;
      end else if (!stall) begin
         if (in_valid) begin
            q     <= d;
            vld_q <= 1'b1;
         end else begin
            vld_q <= 1'b0;
            q.rw  <= 1'b0;
         end
      end
   end

   assign in_ready      = !stall;
   assign out_valid     = vld_q;
   assign alu_input1    = q.a1;
   assign alu_input2    = q.a2;
   assign alu_operation = q.op;
   assign out_rd        = q.rd;
   assign out_reg_write = q.rw;
   assign out_rs2_data  = q.rs2;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: each driven cycle pushes the expected
// register contents, which are popped and compared after the clock edge.
module tb_alu_operand_stage;

   logic        clk, rst, in_valid, in_ready;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd, out_rd;
   logic [31:0] rs1_data, rs2_data, pc, imm, exmem_result, memwb_result;
   logic        src1_sel, src2_sel, reg_write, stall, flush;
   logic        exmem_regwrite, memwb_regwrite;
   logic [3:0]  alu_op, alu_operation;
   logic        out_valid, out_reg_write;
   logic [31:0] alu_input1, alu_input2, out_rs2_data;

   alu_operand_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .pc(pc), .imm(imm), .src1_sel(src1_sel), .src2_sel(src2_sel), .alu_op(alu_op),
      .rd_addr(rd_addr), .reg_write(reg_write), .stall(stall), .flush(flush),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_regwrite(exmem_regwrite),
      .memwb_regwrite(memwb_regwrite), .exmem_result(exmem_result), .memwb_result(memwb_result),
      .out_valid(out_valid), .alu_input1(alu_input1), .alu_input2(alu_input2),
      .alu_operation(alu_operation), .out_rd(out_rd), .out_reg_write(out_reg_write),
      .out_rs2_data(out_rs2_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v, rw, all;
      logic [31:0] a1, a2, rs2;
      logic [3:0]  op;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] rf);
`ifdef ALU_OPERAND_FORWARDING_EN
      if (a != 0 && exmem_regwrite && exmem_rd == a) return exmem_result;
      if (a != 0 && memwb_regwrite && memwb_rd == a) return memwb_result;
`endif
      return rf;
   endfunction

   task automatic idle();
      rst = 0; in_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0;
      pc = 0; imm = 0; src1_sel = 0; src2_sel = 0; alu_op = 0; rd_addr = 0;
      reg_write = 0; stall = 0; flush = 0; exmem_rd = 0; memwb_rd = 0;
      exmem_regwrite = 0; memwb_regwrite = 0; exmem_result = 0; memwb_result = 0;
   endtask

   // One clock: predict next outputs from the driven inputs, then compare.
   task automatic step();
      exp_t n, e;
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, !stall});
      n = cur; n.all = 0;
      if (rst) begin
         n.v = 0; n.rw = 0; n.a1 = 0; n.a2 = 0; n.rs2 = 0; n.op = 0; n.rd = 0; n.all = 1;
      end else if (flush) begin
         n.v = 0; n.rw = 0;
      end else if (!stall) begin
         if (in_valid) begin
            n.v   = 1;
            n.rw  = reg_write;
            n.a1  = src1_sel ? pc  : mfwd(rs1_addr, rs1_data);
            n.a2  = src2_sel ? imm : mfwd(rs2_addr, rs2_data);
            n.rs2 = mfwd(rs2_addr, rs2_data);
            n.op  = alu_op;
            n.rd  = rd_addr;
         end else begin
            n.v = 0; n.rw = 0;
         end
      end
      sb.push_back(n);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
      chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
      if (e.v || e.all) begin
         chk("alu_input1", alu_input1, e.a1);
         chk("alu_input2", alu_input2, e.a2);
         chk("out_rs2_data", out_rs2_data, e.rs2);
         chk("alu_operation", {28'd0, alu_operation}, {28'd0, e.op});
         chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
      end
      cur = e;
   endtask

   initial begin
      cur = '{default: '0};
      idle();
      rst = 1; in_valid = 1; flush = 1; rs1_data = 32'h1234;
      step();
      step();
      // first capture right after reset release
      idle(); in_valid = 1; rs1_data = 5; rs2_data = 7; reg_write = 1; rd_addr = 9;
      step();
      chk("simple_a1", alu_input1, 32'd5);
      chk("simple_a2", alu_input2, 32'd7);
      // EX/MEM beats MEM/WB
      idle(); in_valid = 1; rs1_addr = 3; rs1_data = 32'h11; alu_op = 4'h3;
      exmem_rd = 3; exmem_result = 32'hAA; memwb_rd = 3; memwb_result = 32'hBB;
      exmem_regwrite = 1; memwb_regwrite = 1;
      step();
      // x0 never forwards
      idle(); in_valid = 1; rs2_addr = 0; rs2_data = 0; exmem_rd = 0;
      exmem_regwrite = 1; exmem_result = 32'hFF; memwb_regwrite = 1; memwb_result = 32'hEE;
      step();
      // immediate path with forwarded store data
      idle(); in_valid = 1; src1_sel = 1; pc = 32'h100; src2_sel = 1; imm = 32'hFFFFFFFC;
      rs2_addr = 4; rs2_data = 32'h99; exmem_rd = 4; exmem_regwrite = 1; exmem_result = 32'h12;
      rs1_addr = 4; rs1_data = 32'h77;
      step();
      // MEM/WB only match
      idle(); in_valid = 1; rs1_addr = 7; rs1_data = 32'h1; rs2_addr = 8; rs2_data = 32'h2;
      memwb_rd = 8; memwb_regwrite = 1; memwb_result = 32'hCAFE; exmem_rd = 8; exmem_result = 32'hDEAD;
      reg_write = 1; rd_addr = 5; alu_op = 4'hA;
      step();
      // bubble
      idle(); step();
      // capture A, stall three cycles with changing inputs, then flush under stall
      idle(); in_valid = 1; rs1_data = 32'hA1; rs2_data = 32'hA2; rs2_addr = 2;
      reg_write = 1; rd_addr = 6; alu_op = 4'h5;
      step();
      for (int i = 0; i < 3; i++) begin
         stall = 1; rs1_data = 32'hB0 + i; rs2_data = 32'hC0 + i;
         exmem_rd = 2; exmem_regwrite = 1; exmem_result = 32'hD0 + i;
         step();
      end
      stall = 1; flush = 1;
      step();
      // flush without stall drops the incoming instruction
      idle(); in_valid = 1; reg_write = 1; flush = 1; rs1_data = 32'h55;
      step();
      // randomised stream
      for (int i = 0; i < 300; i++) begin
         rst            = ($urandom_range(0, 40) == 0);
         in_valid       = ($urandom_range(0, 3) != 0);
         stall          = ($urandom_range(0, 3) == 0);
         flush          = ($urandom_range(0, 9) == 0);
         rs1_addr       = 5'($urandom_range(0, 3));
         rs2_addr       = 5'($urandom_range(0, 3));
         exmem_rd       = 5'($urandom_range(0, 3));
         memwb_rd       = 5'($urandom_range(0, 3));
         exmem_regwrite = 1'($urandom);
         memwb_regwrite = 1'($urandom);
         rs1_data = $urandom; rs2_data = $urandom; pc = $urandom; imm = $urandom;
         exmem_result = $urandom; memwb_result = $urandom;
         src1_sel = 1'($urandom); src2_sel = 1'($urandom);
         alu_op = 4'($urandom); rd_addr = 5'($urandom); reg_write = 1'($urandom);
         step();
      end
      // reset wins over a live, flushing input
      idle(); in_valid = 1; reg_write = 1; rs1_data = 32'h9; step();
      rst = 1; in_valid = 1; flush = 1; step();
      chk("rst_a1", alu_input1, 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- rs1_addr, rs2_addr  in  5  source register indices
- rs1_data, rs2_data  in  32  register-file read data
- pc, imm  in  32  instruction address, sign-extended immediate
- src1_sel  in  1  0 = rs1, 1 = pc
- src2_sel  in  1  0 = rs2, 1 = imm
- alu_op  in  4  ALU operation code, passed through unchanged
- rd_addr  in  5  destination index
- reg_write  in  1  instruction writes rd
- stall  in  1  downstream hold request
- flush  in  1  squash the held instruction
- exmem_rd, memwb_rd  in  5  forwarding source destinations
- exmem_regwrite, memwb_regwrite  in  1  forwarding source write enables
- exmem_result, memwb_result  in  32  forwarding source data
- out_valid  out  1  outputs hold a live instruction
- alu_input1, alu_input2  out  32  ALU operands
- alu_operation  out  4  ALU operation code
- out_rd  out  5  registered rd_addr
- out_reg_write  out  1  registered reg_write, gated by validity
- out_rs2_data  out  32  forwarded rs2 value, used as store data

Function
REQ-003 The stage SHALL be a single pipeline register; latency in_valid to out_valid SHALL be exactly 1 cycle.
REQ-004 in_ready SHALL equal !stall, combinationally.
REQ-005 Capture: in_valid && !stall && !flush -> all outputs load; out_valid <= 1.
REQ-006 Bubble: !in_valid && !stall && !flush -> out_valid <= 0; out_reg_write <= 0; data outputs are don't-care.
REQ-007 Hold: stall && !flush -> every output SHALL retain its value.
REQ-008 Flush SHALL take priority over stall and capture: out_valid <= 0, out_reg_write <= 0; the incoming instruction SHALL be dropped.
REQ-009 Forwarded rsN value: if exmem_regwrite && exmem_rd == rsN_addr && rsN_addr != 0 -> exmem_result; else if the same test on memwb passes -> memwb_result; else rsN_data.
REQ-010 EX/MEM SHALL win over MEM/WB when both match.
REQ-011 rsN_addr == 0 SHALL never forward; the stage SHALL pass rsN_data through.
REQ-012 On capture: alu_input1 <= src1_sel ? pc : fwd_rs1.
REQ-013 On capture: alu_input2 <= src2_sel ? imm : fwd_rs2.
REQ-014 On capture: out_rs2_data <= fwd_rs2, regardless of src2_sel.
REQ-015 Forwarding SHALL be evaluated only in the capture cycle; values held during stall SHALL NOT be re-forwarded.
REQ-016 out_reg_write SHALL be 1 only when out_valid is 1.

Reset
REQ-017 rst SHALL have priority over flush, stall and capture.
REQ-018 On rst, every output register SHALL load zero: out_valid, out_reg_write, operands, alu_operation, out_rd and out_rs2_data.
REQ-019 The first capture SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-020 Macro ALU_OPERAND_FORWARDING_EN, when defined, SHALL enable REQ-009 to REQ-011.
REQ-021 When ALU_OPERAND_FORWARDING_EN is undefined, fwd_rsN SHALL equal rsN_data, and the six forwarding inputs SHALL be present but ignored.

Verification
REQ-022 Simple capture: rst, then in_valid=1, rs1_data=5, rs2_data=7, alu_op=0000, sels=0 -> next cycle alu_input1=5, alu_input2=7, out_valid=1.
REQ-023 Forwarding priority (macro on): rs1_addr=3, exmem_rd=3, exmem_result=0xAA, memwb_rd=3, memwb_result=0xBB, both regwrite=1 -> alu_input1=0xAA.
REQ-024 x0 (macro on): rs2_addr=0, exmem_rd=0, exmem_regwrite=1, exmem_result=0xFF, rs2_data=0 -> alu_input2=0, out_rs2_data=0.
REQ-025 Immediate path: src1_sel=1, pc=0x100, src2_sel=1, imm=0xFFFFFFFC, rs2 forwarded 0x12 -> input1=0x100, input2=0xFFFFFFFC, out_rs2_data=0x12.
REQ-026 Stall versus flush: capture A, then stall=1 for 3 cycles -> outputs frozen and in_ready=0; flush=1 with stall=1 -> next cycle out_valid=0, out_reg_write=0.
REQ-027 Reset mid-stream: rst=1 with in_valid=1 and flush=1 -> next cycle all outputs 0.
